// File: rtl/ddsm_cfg_loader_pkg.sv
// Shared constants, field positions, FSM states and config word for the DDSM serial config loader.
// Imported by the loader RTL and its bench.
package ddsm_cfg_pkg;

    localparam int          CFG_FRAME_LEN    = 24;
    localparam logic [1:0]  CFG_CMD_WRITE    = 2'b10;
    localparam logic [3:0]  CFG_MASH_BIT_MAX = 4'd8;

    localparam int CMD_MSB   = 23;
    localparam int CMD_LSB   = 22;
    localparam int SEED_MSB  = 21;
    localparam int SEED_LSB  = 10;
    localparam int ORDER_MSB = 9;
    localparam int ORDER_LSB = 8;
    localparam int MASH_MSB  = 7;
    localparam int MASH_LSB  = 4;
    localparam int MRST_BIT  = 3;
    localparam int PADJ_BIT  = 2;
    localparam int FRAC_BIT  = 1;
    localparam int PAR_BIT   = 0;

    localparam int         CNT_W   = 5;
    localparam logic [4:0] CNT_SAT = 5'd25;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } cfg_state_e;

    typedef struct packed {
        logic [11:0] seed;
        logic [1:0]  sel_order;
        logic [3:0]  mash_bit;
        logic        mashreseten;
        logic        phaseadjusten;
        logic        sel_frac;
    } cfg_t;

    function automatic logic mash_bit_ok(input logic [3:0] m);
        return (m <= CFG_MASH_BIT_MAX);
    endfunction

endpackage

// File: rtl/ddsm_cfg_loader_if.sv
// Configuration word handed from the serial loader (master) to the DDSM input-sync stage (slave).
// All fields change together, qualified by a one-cycle o_cfg_valid pulse.
interface ddsm_cfg_loader_if;
    logic [11:0] o_seed;
    logic [1:0]  o_sel_order;
    logic [3:0]  o_mash_bit;
    logic        o_mashreseten;
    logic        o_phaseadjusten;
    logic        o_sel_frac;
    logic        o_cfg_valid;

    modport master (
        output o_seed, o_sel_order, o_mash_bit, o_mashreseten,
               o_phaseadjusten, o_sel_frac, o_cfg_valid
    );

    modport slave (
        input  o_seed, o_sel_order, o_mash_bit, o_mashreseten,
               o_phaseadjusten, o_sel_frac, o_cfg_valid
    );
endinterface

// File: rtl/ddsm_cfg_loader_sync.sv
// cfg_sync_2ff: 1-bit two-stage synchroniser with async active-high reset to RST_VAL.
// Latency 2 cycles; no backpressure.
module cfg_sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/ddsm_cfg_loader.sv
// Serial 3-wire config loader: validates 24-bit WRITE frames and atomically updates the DDSM config word.
// Latency: outputs update 4 cycles after csn pin rises; no backpressure (source paces sclk). Parity check under DDSM_CFG_PARITY_CHECK_EN.
module ddsm_cfg_loader
    import ddsm_cfg_pkg::*;
#(
    parameter int FRAME_LEN = CFG_FRAME_LEN
) (
    input  logic                i_clk,
    input  logic                i_ff_rst,
    input  logic                i_csn,
    input  logic                i_sclk,
    input  logic                i_sdi,
    ddsm_cfg_loader_if.master   cfg,
    output logic                o_frame_err,
    output logic                o_busy
);

    logic csn_s, sclk_s, sdi_s;
    logic csn_d3, sclk_d3;
    logic csn_rise, sclk_rise;

    // csn syncs to its idle (high) level so reset never looks like a frame start.
    cfg_sync_2ff #(.RST_VAL(1'b1)) u_sync_csn  (.clk(i_clk), .rst(i_ff_rst), .d(i_csn),  .q(csn_s));
    cfg_sync_2ff #(.RST_VAL(1'b0)) u_sync_sclk (.clk(i_clk), .rst(i_ff_rst), .d(i_sclk), .q(sclk_s));
    cfg_sync_2ff #(.RST_VAL(1'b0)) u_sync_sdi  (.clk(i_clk), .rst(i_ff_rst), .d(i_sdi),  .q(sdi_s));

    always_ff @(posedge i_clk or posedge i_ff_rst) begin
        if (i_ff_rst) begin
            csn_d3  <= 1'b1;
            sclk_d3 <= 1'b0;
        end else begin
            csn_d3  <= csn_s;
            sclk_d3 <= sclk_s;
        end
    end

    assign csn_rise  = csn_s  & ~csn_d3;
    assign sclk_rise = sclk_s & ~sclk_d3;

    cfg_state_e             state, state_nxt;
    logic [FRAME_LEN-1:0]   shreg;
    logic [CNT_W-1:0]       cnt;
    logic                   clr, shift_en, load, reject;
    logic                   frame_ok, par_ok;
    cfg_t                   cfg_q, frame_cfg;
    logic                   cfg_valid_q, frame_err_q;

`ifdef DDSM_CFG_PARITY_CHECK_EN
    assign par_ok = ~^shreg;
`else
    assign par_ok = 1'b1;
`endif

    assign frame_ok = (cnt == CNT_W'(FRAME_LEN))
                    && (shreg[CMD_MSB:CMD_LSB] == CFG_CMD_WRITE)
                    && mash_bit_ok(shreg[MASH_MSB:MASH_LSB])
                    && par_ok;

    assign frame_cfg = '{
        seed:          shreg[SEED_MSB:SEED_LSB],
        sel_order:     shreg[ORDER_MSB:ORDER_LSB],
        mash_bit:      shreg[MASH_MSB:MASH_LSB],
        mashreseten:   shreg[MRST_BIT],
        phaseadjusten: shreg[PADJ_BIT],
        sel_frac:      shreg[FRAC_BIT]
    };

    always_ff @(posedge i_clk or posedge i_ff_rst) begin
        if (i_ff_rst) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        clr       = 1'b0;
        shift_en  = 1'b0;
        load      = 1'b0;
        reject    = 1'b0;
        case (state)
            IDLE: begin
                if (!csn_s) begin
                    state_nxt = SHIFT;
                    clr       = 1'b1;
                end
            end
            SHIFT: begin
                shift_en = sclk_rise;
                if (csn_rise) state_nxt = CHECK;
            end
            CHECK: begin
                state_nxt = IDLE;
                load      = frame_ok;
                reject    = ~frame_ok;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_ff_rst) begin
        if (i_ff_rst) begin
            shreg       <= '0;
            cnt         <= '0;
            cfg_q       <= '0;
            cfg_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            cfg_valid_q <= load;
            frame_err_q <= reject;
            if (load) cfg_q <= frame_cfg;
            if (clr) begin
                shreg <= '0;
                cnt   <= '0;
            end else if (shift_en) begin
                shreg <= {shreg[FRAME_LEN-2:0], sdi_s};
                if (cnt != CNT_SAT) cnt <= cnt + 5'd1;
            end
        end
    end

    assign cfg.o_seed          = cfg_q.seed;
    assign cfg.o_sel_order     = cfg_q.sel_order;
    assign cfg.o_mash_bit      = cfg_q.mash_bit;
    assign cfg.o_mashreseten   = cfg_q.mashreseten;
    assign cfg.o_phaseadjusten = cfg_q.phaseadjusten;
    assign cfg.o_sel_frac      = cfg_q.sel_frac;
    assign cfg.o_cfg_valid     = cfg_valid_q;
    assign o_frame_err         = frame_err_q;
    assign o_busy              = (state != IDLE);

endmodule

// File: tb/tb_ddsm_cfg_loader.sv
// Directed bench for ddsm_cfg_loader: table of frames plus hand-written multi-cycle sequences.
module tb_ddsm_cfg_loader;
    import ddsm_cfg_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic csn = 1'b1;
    logic sclk = 1'b0;
    logic sdi = 1'b0;
    logic frame_err, busy;

    ddsm_cfg_loader_if cif();

    ddsm_cfg_loader dut (
        .i_clk       (clk),
        .i_ff_rst    (rst),
        .i_csn       (csn),
        .i_sclk      (sclk),
        .i_sdi       (sdi),
        .cfg         (cif),
        .o_frame_err (frame_err),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

`ifdef DDSM_CFG_PARITY_CHECK_EN
    localparam logic PAR_ACC = 1'b0;
`else
    localparam logic PAR_ACC = 1'b1;
`endif

    int n_pass = 0;
    int n_chk  = 0;
    int n_valid = 0;
    int n_err   = 0;

    always @(negedge clk) begin
        if (cif.o_cfg_valid) n_valid++;
        if (frame_err)       n_err++;
    end

    typedef struct {
        logic [31:0] data;
        int          n;
        logic        acc;
        cfg_t        exp;
        string       nm;
    } vec_t;

    vec_t tv[8];
    cfg_t c_a, c_b, c_c;

    function automatic cfg_t cur_cfg();
        return {cif.o_seed, cif.o_sel_order, cif.o_mash_bit,
                cif.o_mashreseten, cif.o_phaseadjusten, cif.o_sel_frac};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic send_bits(input logic [31:0] data, input int n, input bit open, input bit close);
        if (open) begin
            csn = 1'b0;
            repeat (3) tick();
            chk("busy_in_frame", {31'd0, busy}, 32'd1);
        end
        for (int i = n - 1; i >= 0; i--) begin
            sdi = data[i];
            repeat (3) tick();
            sclk = 1'b1;
            repeat (3) tick();
            sclk = 1'b0;
        end
        if (close) begin
            repeat (3) tick();
            csn = 1'b1;
        end
    endtask

    task automatic observe(input logic acc, input cfg_t exp, input string nm);
        int   v0, e0;
        logic v4, e4;
        v0 = n_valid;
        e0 = n_err;
        v4 = 1'b0;
        e4 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 4) begin
                v4 = cif.o_cfg_valid;
                e4 = frame_err;
            end
        end
        chk({nm, "_pulse_at_4"}, {30'd0, v4, e4}, {30'd0, acc, ~acc});
        chk({nm, "_valid_cnt"}, n_valid - v0, {31'd0, acc});
        chk({nm, "_err_cnt"}, n_err - e0, {31'd0, ~acc});
        chk({nm, "_cfg"}, {11'd0, cur_cfg()}, {11'd0, exp});
        chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   v0, e0;
        logic any_busy;

        c_a = {12'hA5C, 2'b11, 4'h5, 1'b1, 1'b0, 1'b1};
        c_b = {12'h123, 2'b01, 4'h3, 1'b0, 1'b1, 1'b0};
        c_c = {12'hFFF, 2'b10, 4'h8, 1'b0, 1'b0, 1'b1};

        tv[0] = '{32'h00A9735B, 24, 1'b1,    c_a, "valid_a"};
        tv[1] = '{32'h00A9735A, 24, PAR_ACC, c_a, "bad_parity"};
        tv[2] = '{32'h00848D35, 24, 1'b1,    c_b, "valid_b"};
        tv[3] = '{32'h0054B9AD, 23, 1'b0,    c_b, "short_23"};
        tv[4] = '{32'h0152E6B7, 25, 1'b0,    c_b, "long_25"};
        tv[5] = '{32'h00A973CB, 24, 1'b0,    c_b, "mash_c"};
        tv[6] = '{32'h0069735B, 24, 1'b0,    c_b, "cmd_01"};
        tv[7] = '{32'h00BFFE82, 24, 1'b1,    c_c, "mash_max"};

        // Reset state
        repeat (3) tick();
        chk("reset_cfg", {11'd0, cur_cfg()}, 32'd0);
        chk("reset_flags", {29'd0, cif.o_cfg_valid, frame_err, busy}, 32'd0);
        rst = 1'b0;
        repeat (4) tick();
        chk("idle_after_reset", {30'd0, busy, frame_err}, 32'd0);

        for (int t = 0; t < 8; t++) begin
            send_bits(tv[t].data, tv[t].n, 1'b1, 1'b1);
            observe(tv[t].acc, tv[t].exp, tv[t].nm);
        end

        // sclk toggling with csn high must be ignored
        v0 = n_valid;
        e0 = n_err;
        any_busy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sclk = 1'b1;
            repeat (3) begin tick(); any_busy |= busy; end
            sclk = 1'b0;
            repeat (3) begin tick(); any_busy |= busy; end
        end
        chk("idle_sclk_busy", {31'd0, any_busy}, 32'd0);
        chk("idle_sclk_pulses", (n_valid - v0) + (n_err - e0), 32'd0);
        chk("idle_sclk_cfg", {11'd0, cur_cfg()}, {11'd0, c_c});

        // Back-to-back frames with minimum csn-high gap
        v0 = n_valid;
        e0 = n_err;
        send_bits(32'h00A9735B, 24, 1'b1, 1'b1);
        repeat (3) tick();
        send_bits(32'h00848D35, 24, 1'b1, 1'b1);
        observe(1'b1, c_b, "b2b_second");
        chk("b2b_valid_total", n_valid - v0, 32'd2);
        chk("b2b_err_total", n_err - e0, 32'd0);

        // Reset after 12 bits, then finish the frame
        v0 = n_valid;
        send_bits(32'h00000A97, 12, 1'b1, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_cfg", {11'd0, cur_cfg()}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        tick();
        rst = 1'b0;
        send_bits(32'h0000035B, 12, 1'b0, 1'b1);
        observe(1'b0, '0, "rst_mid_frame");
        chk("rst_mid_no_valid", n_valid - v0, 32'd0);

        send_bits(32'h00848D35, 24, 1'b1, 1'b1);
        observe(1'b1, c_b, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
